// File: rtl/ext_pkg.sv
// Shared types and the extension function for the ext_pipe datapath slice.
// ext_compute works on a MAX_W-wide container so that one function serves any
// OUT_W/IMM_W pairing; callers pass their widths and slice the result.
package ext_pkg;

  localparam int unsigned MAX_W = 128;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_SIGN = 3'd1,
    OP_LUI  = 3'd2,
    OP_LB   = 3'd3,
    OP_LBU  = 3'd4,
    OP_LH   = 3'd5,
    OP_LHU  = 3'd6,
    OP_PASS = 3'd7
  } ext_op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Returns {err, result}; result bits above out_w are don't-care for the caller.
  function automatic logic [MAX_W:0] ext_compute(
    input logic [MAX_W-1:0] data,
    input logic [1:0]       addr_lo,
    input ext_op_t          op,
    input int unsigned      out_w,
    input int unsigned      imm_w
  );
    logic [MAX_W-1:0] imm_mask;
    logic [MAX_W-1:0] imm;
    logic             imm_sign;
    logic [MAX_W-1:0] byte_v;
    logic [MAX_W-1:0] half_v;
    logic [MAX_W-1:0] res;
    logic             err;

    imm_mask = ~({MAX_W{1'b1}} << imm_w);
    imm      = data & imm_mask;
    imm_sign = |(data & (MAX_W'(1) << (imm_w - 1)));
    byte_v   = (data >> (8 * addr_lo)) & MAX_W'(8'hFF);
    // Half select uses only addr_lo[1]; addr_lo[0] flags misalignment.
    half_v   = (data >> (addr_lo[1] ? 16 : 0)) & MAX_W'(16'hFFFF);
    res      = '0;
    err      = 1'b0;

    case (op)
      OP_ZERO: res = imm;
      OP_SIGN: res = imm_sign ? (imm | ~imm_mask) : imm;
      OP_LUI:  res = imm << (out_w - imm_w);
      OP_LB:   res = byte_v[7] ? (byte_v | ~MAX_W'(8'hFF)) : byte_v;
      OP_LBU:  res = byte_v;
      OP_LH: begin
        if (addr_lo[0]) err = 1'b1;
        else            res = half_v[15] ? (half_v | ~MAX_W'(16'hFFFF)) : half_v;
      end
      OP_LHU: begin
        if (addr_lo[0]) err = 1'b1;
        else            res = half_v;
      end
      OP_PASS: res = data;
    endcase

    return {err, res};
  endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: registered main output stage plus
// one skid slot. in_ready is a function of registered state and reset only.
// Ports: clk, rst_n (async active-low), flush (sync drop-all),
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t r_state;
  skid_state_t w_state_next;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic w_accept;
  logic w_release;
  logic w_load_main;
  logic w_load_skid;
  logic w_skid_to_main;

  assign in_ready  = rst_n && (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // Next-state and datapath load selects
  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (!flush) begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_next = ONE;
            w_load_main  = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_release) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = TWO;
            w_load_skid  = 1'b1;
          end else if (w_release) begin
            w_state_next = EMPTY;
          end
        end
        TWO: begin
          if (w_release) begin
            w_state_next   = ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end else begin
      w_state_next = EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_next;
  end

  // Payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main)         r_main <= in_data;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= in_data;
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate / load-data extender with a 2-entry skid output stage.
// Ports: clk, reset (async active-low), flush; in_valid/in_ready/in_data/
//        in_addr_lo/in_op upstream; out_valid/out_ready/out_data/out_err
//        downstream; err_count saturating count of accepted misaligned halves.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUT_W-1:0]    in_data,
  input  logic [1:0]          in_addr_lo,
  input  logic [2:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned PAY_W = OUT_W + 1;

  logic [MAX_W:0]       w_ext;
  logic [OUT_W-1:0]     w_res;
  logic                 w_err;
  logic [PAY_W-1:0]     w_pay_in;
  logic [PAY_W-1:0]     w_pay_out;
  logic                 w_in_ready;
  logic [ERRCNT_W-1:0]  r_err_count;

  assign w_ext    = ext_compute(MAX_W'(in_data), in_addr_lo, ext_op_t'(in_op), OUT_W, IMM_W);
  assign w_err    = w_ext[MAX_W];
  assign w_res    = OUT_W'(w_ext[MAX_W-1:0]);
  assign w_pay_in = {w_err, w_res};

  ext_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_pay_out)
  );

  assign in_ready  = w_in_ready;
  assign out_err   = w_pay_out[PAY_W-1];
  assign out_data  = w_pay_out[OUT_W-1:0];
  assign err_count = r_err_count;

  // Saturating misalignment counter; entries dropped by flush are not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (in_valid && w_in_ready && !flush && w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender in the datapath.
- Covers the immediate modes (zero, sign, lui-shift) and the load-data modes (lb/lbu/lh/lhu byte/half extraction by address offset), plus a pass-through mode.
- Sits between the DM read / immediate source and the writeback/ALU-B mux.
- Uses a 1-cycle registered output stage with a 2-entry skid buffer and valid/ready handshake, so that upstream stalls are absorbed.

Parameters:
- OUT_W, 32: output word width; must be a multiple of 16 and at least 32.
- IMM_W, 16: immediate field width, taken from in_data[IMM_W-1:0]; must be less than OUT_W.
- ERRCNT_W, 8: width of the saturating misalignment error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- flush  input  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  OUT_W  immediate (low IMM_W bits) or loaded word.
- in_addr_lo  input  2  byte offset for the load modes.
- in_op  input  3  ext_op_t mode select.
- out_valid  output  1  out_data/out_err hold a valid entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_data  output  OUT_W  extended result.
- out_err  output  1  the entry was a misaligned halfword load.
- err_count  output  ERRCNT_W  saturating count of accepted misaligned entries.

Behaviour:
- Modes, computed combinationally on the input side and then registered:
  - 0 ZERO: {0, imm}.
  - 1 SIGN: sign-extend imm.
  - 2 LUI: imm << (OUT_W-IMM_W), low bits 0.
  - 3 LB: sign-extend byte in_data[8*addr_lo +: 8].
  - 4 LBU: zero-extend the same byte.
  - 5 LH: sign-extend half in_data[16*addr_lo[1] +: 16].
  - 6 LHU: zero-extend the same half.
  - 7 PASS: in_data unchanged.
- Misalignment: in modes 5/6 with addr_lo[0]=1, out_data=0 and out_err=1. In every other mode addr_lo[0] is ignored for halves and out_err=0.
- Transfer rules: an accept happens when in_valid && in_ready; a release happens when out_valid && out_ready.
- Latency: an entry accepted in cycle N is visible on out_* from cycle N+1 when the output stage is empty or releasing.
- Storage: output register (main) plus skid register.
  - in_ready = reset deasserted && !skid_valid.
  - in_ready depends only on registered state, with no combinational path from out_ready.
- State machine: EMPTY, ONE (main only), TWO (main + skid).
  - EMPTY: accept -> ONE.
  - ONE: accept and release -> ONE (main reloads); accept only -> TWO (entry goes to skid); release only -> EMPTY.
  - TWO: release -> ONE (skid moves to main, in_ready=0 that cycle); no release -> stay TWO.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data/out_err stay stable.
- flush: at the next edge, state goes to EMPTY and out_valid=0. An entry presented in the flush cycle is discarded and not counted. err_count is unchanged.
- err_count: increments by 1 at each accept with a misaligned result and saturates at 2^ERRCNT_W-1. Only reset clears it.
- Reset (async assert while reset=0):
  - state EMPTY; out_valid=0, out_data=0, out_err=0, err_count=0, in_ready=0.
  - in_ready goes to 1 on the first cycle after deassertion.
  - Asserting reset mid-transfer drops all entries immediately.

Decomposition:
- Package ext_pkg:
  - typedef ext_op_t (3-bit enum ZERO..PASS).
  - typedef skid_state_t (EMPTY/ONE/TWO).
  - function ext_compute(data, addr_lo, op) returning {err, result}.
- Sub-module ext_skid_buf: generic 2-entry valid/ready skid buffer, parametrised on payload width OUT_W+1. ext_pipe instantiates it after ext_compute.

Test Plan:
- Immediate modes, out_ready=1:
  - in_data=0x0000_8001, ZERO -> 0x0000_8001.
  - SIGN -> 0xFFFF_8001.
  - LUI -> 0x8001_0000.
  - Each result appears exactly 1 cycle after its accept, back-to-back at 1 per cycle.
- Load modes on in_data=0x80FF_7F01:
  - LB addr_lo=1 -> 0x0000_007F; LB addr_lo=2 -> 0xFFFF_FFFF.
  - LBU addr_lo=3 -> 0x0000_0080.
  - LH addr_lo=2 -> 0xFFFF_80FF; LHU addr_lo=0 -> 0x0000_7F01.
- Misaligned: LH addr_lo=1 -> out_data=0, out_err=1, err_count 0->1. Then 300 misaligned accepts with ERRCNT_W=8 -> err_count holds 255.
- Backpressure: out_ready=0 while sending A=1 then B=2 (SIGN) -> in_ready=0 after B, out_data stays 1. Raise out_ready -> outputs 1 then 2 in order, and in_ready returns to 1 one cycle after the first release.
- Flush in state TWO with a new entry C presented -> next cycle out_valid=0, C is never output, err_count is unchanged.
- Assert reset=0 asynchronously mid-cycle in state TWO -> out_valid, out_data, out_err and err_count go to 0 before the next edge; after release, in_ready=1 and the first accept behaves as from EMPTY.
